regfile_pipe: RTL and testbench
===============================

# regfile_pipe

Parametrised CPU register file for the Zet core, the successor to the single-cycle 16-bit register file. It adds configurable data width, a configurable number of read ports, a one-entry registered write stage with optional forwarding, and a CX auto-decrement path for REP string loops. It sits between the decoder/microcode sequencer, which supplies addresses and controls, and the ALU, which supplies `d` and `iflags`.

## Interface
- `DW`, 16: register width; legal values are 16 and 32.
- `NRD`, 3: number of general read ports, 1..4.
- `FLW`, 9: flags width.
- `clk` in 1: the only clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr_rd` in 4*NRD: read address of port k at bits [4k+3:4k].
- `byte_rd` in NRD: byte-mode read, one bit per port.
- `rd_data` out DW*NRD: read data of port k at bits [DW*k+DW-1:DW*k].
- `addr_s` in 2: segment select.
- `s` out DW: selected segment register, r[{2'b10,addr_s}].
- `cs` out DW: r[9].
- `ip` out DW: r[15].
- `wr` in 1: write request.
- `addr_d` in 4: write address.
- `d` in 2*DW: write data; the low half is the result, the high half is used by `wrhi`.
- `word_op` in 1: full-width write.
- `wrhi` in 1: write `d[2*DW-1:DW]` to r[2] (DX).
- `dec_cx` in 1: decrement r[1] (CX) by 1.
- `wr_ip0` in 1: copy IP into r[14].
- `wrfl` in 1: load flags.
- `iflags` in FLW: flags input.
- `flags` out FLW: flags register.
- `cx_zero` out 1: CX as seen by readers equals 0.

## Operation
- The file holds 16 registers of DW bits.
  - 0-7: AX CX DX BX SP BP SI DI.
  - 8-11: segment registers; 9 is CS.
  - 12-13: temporaries.
  - 14: IP0.
  - 15: IP.
- Reset values: all registers 0 except r[9] = 16'hF000 and r[15] = 16'hFFF0 (zero-extended when DW=32). `flags` = 0. The write stage is empty.
- Byte-mode read (`byte_rd[k]` set and `addr_rd[3]` = 0):
  - Addresses 0-3 return the low byte of r[a].
  - Addresses 4-7 return bits [15:8] of r[a[1:0]].
  - The byte is sign-extended to DW.
  - With `addr_rd[3]` = 1, byte mode is ignored and the full register is returned.
- Write merge, applied when the write stage commits:
  - `word_op` = 1: r[a] <= d[DW-1:0].
  - `word_op` = 0, a in 8-11: r[a] <= sign-extended d[7:0].
  - `word_op` = 0, a in 0-3 or 12-15: r[a][7:0] <= d[7:0].
  - `word_op` = 0, a in 4-7: r[a[1:0]][15:8] <= d[7:0].
- Write stage:
  - Controls `wr`, `addr_d`, `d`, `word_op`, `wrhi` and `dec_cx` are captured at edge N.
  - The captured operation commits to the array at edge N+1.
  - A new request may be captured at every edge, so throughput is one write per cycle.
- Commit priority, highest first:
  - `rst`.
  - `wr_ip0` on r[14].
  - `wrhi` on r[2].
  - The port write.
  - `dec_cx` on r[1]. It is dropped if the port write or `wrhi` targets the same register.
- `dec_cx` wraps: 0 decrements to all-ones.
- `wr_ip0` is not staged. At edge N, r[14] <= committed r[15].
- `flags` is not staged. `wrfl` loads `iflags` at the next edge.
- `cx_zero` is combinational on the CX value presented to readers.
- Reset mid-operation: asserting `rst` discards any staged write. No commit occurs on the reset edge.

## Timing
- A write requested in cycle N is in the array from cycle N+2.
- With forwarding, readers see the write from cycle N+1.
- Read ports, `s`, `cs`, `ip` and `cx_zero` are combinational: zero latency from address to data.
- Back-to-back writes to the same register in cycles N and N+1: the N+1 merge applies on top of the N result. Byte merges must compose correctly.
- There is no backpressure; `wr` is accepted every cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Every read path (`rd_data`, `s`, `cs`, `ip`, `cx_zero`) returns the post-commit value of any register targeted by the staged operation.
  - This covers the port write, `wrhi` and `dec_cx`, with merge and priority applied.
- `REGFILE_BYPASS_EN` undefined:
  - Read paths return committed array contents only.
  - The sequencer must insert one bubble before reading a just-written register.
  - Area and read path are smaller.

## Test plan
- **Reset:** hold `rst` 2 cycles → `cs` = F000, `ip` = FFF0, `flags` = 0, every `rd_data` = 0.
- **Byte write and read:** `wr`, `addr_d` = 4, `word_op` = 0, d = 0x85, with AX = 0x1234 → AX = 0x8534 after commit. A byte read of address 4 returns 0xFF85; a byte read of address 0 returns 0x0034.
- **Forwarding and latency:** word write 0xBEEF to r[3] in cycle N, read r[3] in cycle N+1.
  - Bypass build: 0xBEEF.
  - Non-bypass build: old value in N+1, 0xBEEF in N+2.
- **Collisions:** `wrhi` with d = 0x0007_0003 and `addr_d` = 2, `word_op` = 1 → DX = 0x0007.
- **CX decrement:** CX = 1, pulse `dec_cx` → `cx_zero` = 1 (at N+1 with bypass, N+2 without). A further `dec_cx` → CX = 0xFFFF.
- **Reset mid-write:** assert `wr` to r[1] with d = 0x5555, then `rst` on the next edge → CX = 0 and no later commit.

Source files
------------

// File: rtl/regfile_pipe.sv
// regfile_pipe: 16-entry CPU register file with a one-entry registered write
// stage, byte-merge writes, DX high-half write, CX auto-decrement and IP0 copy.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the staged write to
// every read path (rd_data, s, cs, ip, cx_zero). Without it, reads return the
// committed array only and the sequencer must leave one bubble after a write.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   addr_rd/byte_rd per-port read address (4 bits each) and byte-mode select
//   rd_data         per-port read data (DW bits each), combinational
//   addr_s / s      segment select and selected segment register
//   cs, ip          r[9] and r[15]
//   wr, addr_d, d   write request, address, data (high half feeds wrhi)
//   word_op         full-width write (otherwise byte merge)
//   wrhi            write d high half to DX (r[2])
//   dec_cx          decrement CX (r[1])
//   wr_ip0          copy committed IP into r[14] (not staged)
//   wrfl, iflags    load flags register (not staged)
//   flags           flags register
//   cx_zero         CX as seen by readers equals zero
module regfile_pipe #(
    parameter int unsigned DW  = 16,
    parameter int unsigned NRD = 3,
    parameter int unsigned FLW = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NRD-1:0]    addr_rd,
    input  logic [NRD-1:0]      byte_rd,
    output logic [DW*NRD-1:0]   rd_data,
    input  logic [1:0]          addr_s,
    output logic [DW-1:0]       s,
    output logic [DW-1:0]       cs,
    output logic [DW-1:0]       ip,
    input  logic                wr,
    input  logic [3:0]          addr_d,
    input  logic [2*DW-1:0]     d,
    input  logic                word_op,
    input  logic                wrhi,
    input  logic                dec_cx,
    input  logic                wr_ip0,
    input  logic                wrfl,
    input  logic [FLW-1:0]      iflags,
    output logic [FLW-1:0]      flags,
    output logic                cx_zero
);

    localparam int unsigned NREG = 16;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [DW-1:0]   post   [NREG];
    logic [DW-1:0]   view   [NREG];

    logic            stg_wr_q,   stg_wr_d;
    logic [3:0]      stg_addr_q, stg_addr_d;
    logic [2*DW-1:0] stg_data_q, stg_data_d;
    logic            stg_word_q, stg_word_d;
    logic            stg_wrhi_q, stg_wrhi_d;
    logic            stg_dec_q,  stg_dec_d;
    logic [FLW-1:0]  flags_q,    flags_d;

    logic [3:0]      wtgt;

    // Merge a port write into the old register value.
    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0] old,
        input logic [3:0]    a,
        input logic          word,
        input logic [DW-1:0] w
    );
        logic [DW-1:0] m;
        logic [7:0]    b;
        m = old;
        b = w[7:0];
        if (word) begin
            m = w;
        end else if (a[3:2] == 2'b10) begin
            m = {{(DW-8){b[7]}}, b};
        end else if (a[3:2] == 2'b01) begin
            m[15:8] = b;
        end else begin
            m[7:0] = b;
        end
        return m;
    endfunction

    // Byte writes to 4-7 land in the high byte of registers 0-3.
    always_comb begin
        wtgt = stg_addr_q;
        if (!stg_word_q && (stg_addr_q[3:2] == 2'b01)) begin
            wtgt = {2'b00, stg_addr_q[1:0]};
        end
    end

    // Post-commit image of the array: dec_cx < port write < wrhi.
    always_comb begin
        post = regs_q;
        if (stg_dec_q && !(stg_wr_q && (wtgt == 4'd1))) begin
            post[1] = regs_q[1] - DW'(1);
        end
        if (stg_wr_q) begin
            post[wtgt] = merge(regs_q[wtgt], stg_addr_q, stg_word_q, stg_data_q[DW-1:0]);
        end
        if (stg_wrhi_q) begin
            post[2] = stg_data_q[2*DW-1:DW];
        end
    end

    // Value presented to all readers.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        view = post;
`else
        view = regs_q;
`endif
    end

    // Next array state; wr_ip0 takes IP from the committed array.
    always_comb begin
        regs_d = post;
        if (wr_ip0) begin
            regs_d[14] = regs_q[15];
        end
    end

    // Capture stage and flags.
    always_comb begin
        stg_wr_d   = wr;
        stg_addr_d = addr_d;
        stg_data_d = d;
        stg_word_d = word_op;
        stg_wrhi_d = wrhi;
        stg_dec_d  = dec_cx;
        flags_d    = flags_q;
        if (wrfl) begin
            flags_d = iflags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            regs_q[9]  <= DW'(16'hF000);
            regs_q[15] <= DW'(16'hFFF0);
            stg_wr_q   <= 1'b0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            stg_word_q <= 1'b0;
            stg_wrhi_q <= 1'b0;
            stg_dec_q  <= 1'b0;
            flags_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            stg_wr_q   <= stg_wr_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            stg_word_q <= stg_word_d;
            stg_wrhi_q <= stg_wrhi_d;
            stg_dec_q  <= stg_dec_d;
            flags_q    <= flags_d;
        end
    end

    // General read ports with sign-extended byte mode for addresses 0-7.
    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [3:0] a;
        logic [7:0] b;
        assign a = addr_rd[4*k +: 4];
        assign b = a[2] ? view[{2'b00, a[1:0]}][15:8] : view[{2'b00, a[1:0]}][7:0];
        assign rd_data[DW*k +: DW] = (byte_rd[k] && !a[3]) ? {{(DW-8){b[7]}}, b} : view[a];
    end

    assign s       = view[{2'b10, addr_s}];
    assign cs      = view[9];
    assign ip      = view[15];
    assign cx_zero = (view[1] == '0);
    assign flags   = flags_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Scoreboard bench for regfile_pipe: a driver computes expected outputs from an
// abstract model and queues them; a monitor compares them at the falling edge.
module tb_regfile_pipe;

    localparam int unsigned DW  = 16;
    localparam int unsigned NRD = 3;
    localparam int unsigned FLW = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic [4*NRD-1:0]    addr_rd;
    logic [NRD-1:0]      byte_rd;
    logic [DW*NRD-1:0]   rd_data;
    logic [1:0]          addr_s;
    logic [DW-1:0]       s, cs, ip;
    logic                wr;
    logic [3:0]          addr_d;
    logic [2*DW-1:0]     d;
    logic                word_op, wrhi, dec_cx, wr_ip0, wrfl;
    logic [FLW-1:0]      iflags, flags;
    logic                cx_zero;

    regfile_pipe #(.DW(DW), .NRD(NRD), .FLW(FLW)) dut (
        .clk(clk), .rst(rst), .addr_rd(addr_rd), .byte_rd(byte_rd),
        .rd_data(rd_data), .addr_s(addr_s), .s(s), .cs(cs), .ip(ip),
        .wr(wr), .addr_d(addr_d), .d(d), .word_op(word_op), .wrhi(wrhi),
        .dec_cx(dec_cx), .wr_ip0(wr_ip0), .wrfl(wrfl), .iflags(iflags),
        .flags(flags), .cx_zero(cx_zero)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] arr_t [16];
    typedef struct {
        logic [47:0] rd;
        logic [15:0] s, cs, ip;
        logic [8:0]  fl;
        logic        cz;
    } exp_t;

    exp_t        sb[$];
    arr_t        m;
    logic [8:0]  m_flags;
    logic        p_wr, p_wrhi, p_dec, p_word;
    logic [3:0]  p_addr;
    logic [31:0] p_d;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Registers after the pending operation lands.
    function automatic arr_t apply_pending(input arr_t cur);
        arr_t       r;
        int         tgt;
        logic [7:0] b;
        r   = cur;
        b   = p_d[7:0];
        tgt = int'(p_addr);
        if (!p_word && p_addr >= 4 && p_addr <= 7) tgt = int'(p_addr) - 4;
        if (p_dec && !(p_wr && tgt == 1)) r[1] = cur[1] - 16'd1;
        if (p_wr) begin
            if (p_word)                          r[tgt] = p_d[15:0];
            else if (p_addr >= 8 && p_addr <= 11) r[tgt] = b[7] ? (16'hFF00 | 16'(b)) : 16'(b);
            else if (p_addr >= 4 && p_addr <= 7)  r[tgt] = (cur[tgt] & 16'h00FF) | (16'(b) << 8);
            else                                  r[tgt] = (cur[tgt] & 16'hFF00) | 16'(b);
        end
        if (p_wrhi) r[2] = p_d[31:16];
        return r;
    endfunction

    function automatic arr_t visible();
`ifdef REGFILE_BYPASS_EN
        return apply_pending(m);
`else
        return m;
`endif
    endfunction

    function automatic logic [15:0] rd_model(input arr_t v, input logic [3:0] a, input logic bm);
        logic [7:0] b;
        int         base;
        if (bm && a < 8) begin
            base = int'(a) % 4;
            b = (a >= 4) ? v[base][15:8] : v[base][7:0];
            return b[7] ? (16'hFF00 | 16'(b)) : 16'(b);
        end
        return v[a];
    endfunction

    task automatic push_exp();
        arr_t v;
        exp_t e;
        v = visible();
        for (int k = 0; k < 3; k++) begin
            e.rd[16*k +: 16] = rd_model(v, addr_rd[4*k +: 4], byte_rd[k]);
        end
        e.s  = v[8 + int'(addr_s)];
        e.cs = v[9];
        e.ip = v[15];
        e.fl = m_flags;
        e.cz = (v[1] == 16'd0);
        sb.push_back(e);
    endtask

    task automatic model_edge();
        arr_t n;
        if (rst) begin
            for (int i = 0; i < 16; i++) m[i] = 16'd0;
            m[9]  = 16'hF000;
            m[15] = 16'hFFF0;
            m_flags = 9'd0;
            p_wr = 1'b0; p_wrhi = 1'b0; p_dec = 1'b0; p_word = 1'b0;
            p_addr = 4'd0; p_d = 32'd0;
        end else begin
            n = apply_pending(m);
            if (wr_ip0) n[14] = m[15];
            if (wrfl) m_flags = iflags;
            m = n;
            p_wr = wr; p_wrhi = wrhi; p_dec = dec_cx; p_word = word_op;
            p_addr = addr_d; p_d = d;
        end
    endtask

    task automatic cyc();
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; wrhi = 1'b0; dec_cx = 1'b0; wr_ip0 = 1'b0; wrfl = 1'b0;
        word_op = 1'b0; addr_d = 4'd0; d = 32'd0; iflags = 9'd0;
    endtask

    // Monitor: compare queued expectations against the live outputs.
    always @(negedge clk) begin
        exp_t me;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            cmp("rd_data", 48'(rd_data), me.rd);
            cmp("s",       48'(s),       48'(me.s));
            cmp("cs",      48'(cs),      48'(me.cs));
            cmp("ip",      48'(ip),      48'(me.ip));
            cmp("flags",   48'(flags),   48'(me.fl));
            cmp("cx_zero", 48'(cx_zero), 48'(me.cz));
        end
    end

    initial begin
        idle();
        rst = 1'b1; byte_rd = 3'b000; addr_s = 2'd1;
        addr_rd = {4'd2, 4'd1, 4'd0};
        @(posedge clk);
        model_edge();
        #1;
        cyc();
        rst = 1'b0;
        #1;
        cmp("reset_cs",    48'(cs),    48'h00F000);
        cmp("reset_ip",    48'(ip),    48'h00FFF0);
        cmp("reset_flags", 48'(flags), 48'h0);
        cmp("reset_rd",    48'(rd_data), 48'h0);
        cyc();

        // Word then byte write to AX back to back.
        wr = 1'b1; word_op = 1'b1; addr_d = 4'd0; d = 32'h1234; cyc();
        word_op = 1'b0; addr_d = 4'd4; d = 32'h85; cyc();
        idle(); cyc(); cyc();
        addr_rd = {4'd0, 4'd0, 4'd4}; byte_rd = 3'b011;
        #1;
        cmp("byte_rd_hi", 48'(rd_data[15:0]),  48'hFF85);
        cmp("byte_rd_lo", 48'(rd_data[31:16]), 48'h0034);
        cmp("ax_merged",  48'(rd_data[47:32]), 48'h8534);
        cyc();

        // Forwarding latency on r[3].
        byte_rd = 3'b000; addr_rd = {4'd3, 4'd3, 4'd3};
        wr = 1'b1; word_op = 1'b1; addr_d = 4'd3; d = 32'hBEEF; cyc();
        idle();
        #1;
`ifdef REGFILE_BYPASS_EN
        cmp("fwd_n1", 48'(rd_data[15:0]), 48'hBEEF);
`else
        cmp("fwd_n1", 48'(rd_data[15:0]), 48'h0000);
`endif
        cyc();
        #1;
        cmp("fwd_n2", 48'(rd_data[15:0]), 48'hBEEF);
        cyc();

        // wrhi beats port write on DX.
        wr = 1'b1; word_op = 1'b1; addr_d = 4'd2; wrhi = 1'b1; d = 32'h0007_0003; cyc();
        idle(); cyc();
        addr_rd = {4'd1, 4'd1, 4'd2};
        #1;
        cmp("wrhi_dx", 48'(rd_data[15:0]), 48'h0007);
        cyc();

        // CX decrement to zero and wrap.
        wr = 1'b1; word_op = 1'b1; addr_d = 4'd1; d = 32'd1; cyc();
        idle(); cyc();
        #1;
        cmp("cx_one", 48'(cx_zero), 48'h0);
        dec_cx = 1'b1; cyc();
        dec_cx = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        cmp("cxz_n1", 48'(cx_zero), 48'h1);
`else
        cmp("cxz_n1", 48'(cx_zero), 48'h0);
`endif
        cyc();
        #1;
        cmp("cxz_n2", 48'(cx_zero), 48'h1);
        dec_cx = 1'b1; cyc();
        dec_cx = 1'b0; cyc();
        #1;
        cmp("cx_wrap", 48'(rd_data[31:16]), 48'hFFFF);
        cyc();

        // Reset discards the staged write.
        wr = 1'b1; word_op = 1'b1; addr_d = 4'd1; d = 32'h5555; cyc();
        idle(); rst = 1'b1; cyc();
        rst = 1'b0; cyc();
        #1;
        cmp("rst_mid_cx", 48'(rd_data[31:16]), 48'h0);
        cyc();
        #1;
        cmp("rst_mid_cx2", 48'(rd_data[31:16]), 48'h0);
        cyc();

        // Flags load and IP0 copy.
        wrfl = 1'b1; iflags = 9'h1A5; wr_ip0 = 1'b1; cyc();
        idle(); addr_rd = {4'd1, 4'd1, 4'd14};
        #1;
        cmp("flags_load", 48'(flags), 48'h1A5);
        cmp("ip0_copy",   48'(rd_data[15:0]), 48'hFFF0);
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            addr_rd = 12'($urandom);
            byte_rd = 3'($urandom);
            addr_s  = 2'($urandom);
            wr      = 1'($urandom);
            addr_d  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
            d       = $urandom;
            word_op = 1'($urandom);
            wrhi    = ($urandom_range(0, 7) == 0);
            dec_cx  = ($urandom_range(0, 3) == 0);
            wr_ip0  = ($urandom_range(0, 7) == 0);
            wrfl    = ($urandom_range(0, 3) == 0);
            iflags  = 9'($urandom);
            cyc();
        end

        idle(); rst = 1'b0;
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
